// File: rtl/esp_io_sched_if.sv
// Z80-side decode, ESP handshake and status signals of the ESP I/O scheduler.
// The host side uses master; the scheduler uses slave.
interface esp_io_sched_if;
    logic       io_access;
    logic       sel_trs_io_in;
    logic       sel_trs_io_out;
    logic       sel_frehd_in;
    logic       sel_frehd_out;
    logic       sel_printer_rd;
    logic       sel_printer_wr;
    logic       ESP_DONE;
    logic       ESP_REQ;
    logic [2:0] ESP_S;
    logic       WAIT;
    logic       busy;
    logic       timeout_evt;
    logic       overrun_evt;
    logic [7:0] err_count;

    modport master (
        output io_access, sel_trs_io_in, sel_trs_io_out, sel_frehd_in, sel_frehd_out,
               sel_printer_rd, sel_printer_wr, ESP_DONE,
        input  ESP_REQ, ESP_S, WAIT, busy, timeout_evt, overrun_evt, err_count
    );

    modport slave (
        input  io_access, sel_trs_io_in, sel_trs_io_out, sel_frehd_in, sel_frehd_out,
               sel_printer_rd, sel_printer_wr, ESP_DONE,
        output ESP_REQ, ESP_S, WAIT, busy, timeout_evt, overrun_evt, err_count
    );
endinterface

// File: rtl/esp_io_sched.sv
// ESP I/O request scheduler: turns decoded Z80 port accesses into one ESP request
// at a time, holding the Z80 in WAIT until the ESP signals done or the wait times out.
module esp_io_sched #(
    parameter int unsigned REQ_PULSE      = 50,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8400000
) (
    input  logic          clk,
    input  logic          RST_N,
    esp_io_sched_if.slave bus
);
    // state     | meaning
    // IDLE      | nothing outstanding, ESP_S holds the last code
    // REQ       | ESP_REQ high for REQ_PULSE cycles, Z80 held in WAIT
    // WAIT_DONE | pulse finished, waiting for a done edge or the timeout
    // RELEASE   | one cycle with WAIT and ESP_REQ low before IDLE
    typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, RELEASE} state_t;

    localparam logic [5:0] PULSE_LOAD = 6'(REQ_PULSE - 1);

    state_t      state, state_nx;
    logic [1:0]  arm_sync;
    logic        done_s1, done_s2, done_s3;
    logic [5:0]  pulse_cnt;
    logic [23:0] tmo_cnt;
    logic        done_seen;
    logic        sel_any;
    logic [2:0]  sel_code;
    logic        active, req_ok, overrun, done_edge, pulse_end, tmo_hit, tmo_take;
    logic        esp_req_d, wait_d, busy_d;
    logic        esp_req_q, wait_q, busy_q, timeout_evt_q, overrun_evt_q;
    logic [2:0]  esp_s_q;
    logic [7:0]  err_count_q;

    always_comb begin
        sel_any  = 1'b1;
        sel_code = 3'd0;
        if      (bus.sel_trs_io_in)  sel_code = 3'd0;
        else if (bus.sel_trs_io_out) sel_code = 3'd1;
        else if (bus.sel_frehd_in)   sel_code = 3'd2;
        else if (bus.sel_frehd_out)  sel_code = 3'd3;
        else if (bus.sel_printer_rd) sel_code = 3'd4;
        else if (bus.sel_printer_wr) sel_code = 3'd5;
        else                         sel_any  = 1'b0;
    end

    assign active    = (state == REQ) || (state == WAIT_DONE);
    assign req_ok    = bus.io_access && sel_any && arm_sync[1] && (state == IDLE);
    assign overrun   = bus.io_access && sel_any && (state != IDLE);
    // Edges only count while a request is outstanding; a level already high at entry never makes one.
    assign done_edge = done_s2 && !done_s3 && active;
    assign pulse_end = (state == REQ) && (pulse_cnt == 6'd0);
    assign tmo_hit   = ({1'b0, tmo_cnt} + 25'd1) >= {1'b0, TIMEOUT_CYCLES};
    assign tmo_take  = (state == WAIT_DONE) && tmo_hit && !done_edge;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (req_ok) state_nx = REQ;
            REQ:       if (pulse_end) state_nx = (done_seen || done_edge) ? RELEASE : WAIT_DONE;
            WAIT_DONE: if (done_edge || tmo_hit) state_nx = RELEASE;
            RELEASE:   state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so nothing is combinational to a pin.
    always_comb begin
        esp_req_d = (state_nx == REQ);
        wait_d    = (state_nx == REQ) || (state_nx == WAIT_DONE);
        busy_d    = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            arm_sync      <= 2'b00;
            done_s1       <= 1'b0;
            done_s2       <= 1'b0;
            done_s3       <= 1'b0;
            pulse_cnt     <= 6'd0;
            tmo_cnt       <= 24'd0;
            done_seen     <= 1'b0;
            esp_req_q     <= 1'b0;
            wait_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_evt_q <= 1'b0;
            overrun_evt_q <= 1'b0;
            esp_s_q       <= 3'd0;
            err_count_q   <= 8'd0;
        end else begin
            arm_sync      <= {arm_sync[0], 1'b1};
            done_s1       <= bus.ESP_DONE;
            done_s2       <= done_s1;
            done_s3       <= done_s2;
            esp_req_q     <= esp_req_d;
            wait_q        <= wait_d;
            busy_q        <= busy_d;
            timeout_evt_q <= tmo_take;
            overrun_evt_q <= overrun;
            if (req_ok) begin
                pulse_cnt <= PULSE_LOAD;
                tmo_cnt   <= 24'd0;
                done_seen <= 1'b0;
                esp_s_q   <= sel_code;
            end else begin
                if ((state == REQ) && (pulse_cnt != 6'd0)) pulse_cnt <= pulse_cnt - 6'd1;
                if (active) tmo_cnt <= tmo_cnt + 24'd1;
                if ((state == REQ) && done_edge) done_seen <= 1'b1;
            end
            if (tmo_take && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
        end
    end

    assign bus.ESP_REQ     = esp_req_q;
    assign bus.ESP_S       = esp_s_q;
    assign bus.WAIT        = wait_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_evt = timeout_evt_q;
    assign bus.overrun_evt = overrun_evt_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_esp_io_sched.sv
// Bench for esp_io_sched: directed and random transactions compared against
// a cycle-count model of pulse length, done latency, timeout and overrun rules.
module tb_esp_io_sched;
    localparam int P  = 50;
    localparam int T  = 200;
    localparam int TP = (T > P) ? T : P + 1;

    logic clk   = 1'b0;
    logic RST_N = 1'b0;
    int vectors     = 0;
    int miscompares = 0;
    int err_model   = 0;

    esp_io_sched_if bus ();

    esp_io_sched #(.REQ_PULSE(P), .TIMEOUT_CYCLES(24'(T))) dut (
        .clk   (clk),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sel(input logic [5:0] s);
        bus.sel_trs_io_in  = s[0];
        bus.sel_trs_io_out = s[1];
        bus.sel_frehd_in   = s[2];
        bus.sel_frehd_out  = s[3];
        bus.sel_printer_rd = s[4];
        bus.sel_printer_wr = s[5];
    endtask

    // Highest-priority select is the lowest-numbered bit; its bit index is the ESP code.
    function automatic int prio_code(input logic [5:0] s);
        int  code  = 0;
        bit  found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (s[i] && !found) begin
                code  = i;
                found = 1'b1;
            end
        end
        return code;
    endfunction

    // Cycle (counted in edges after the accepting edge) at which WAIT drops.
    function automatic int exp_fall(input int rise_k);
        if (rise_k < 0)        return TP;
        if (rise_k + 3 <= P)   return P;
        if (rise_k + 3 <= TP)  return rise_k + 3;
        return TP;
    endfunction

    function automatic bit exp_timeout(input int rise_k);
        return (rise_k < 0) || (rise_k + 3 > TP);
    endfunction

    task automatic run_txn(input string tag, input logic [5:0] sel, input bit pre_high,
                           input int rise_k, input int fall_k, input int ovr_k);
        int exp_code, exp_wf, req_cnt, req_last, wf, bf, tmo_n, tmo_at, ovr_n, ovr_at, s_bad;
        bit exp_tmo, fin;
        exp_code = prio_code(sel);
        exp_wf   = exp_fall(rise_k);
        exp_tmo  = exp_timeout(rise_k);
        req_cnt = 0; req_last = -1; wf = -1; bf = -1;
        tmo_n = 0; tmo_at = -1; ovr_n = 0; ovr_at = -1; s_bad = 0; fin = 1'b0;
        if (pre_high) begin
            bus.ESP_DONE = 1'b1;
            repeat (4) tick();
        end
        bus.io_access = 1'b1;
        drive_sel(sel);
        tick();
        for (int j = 0; j < 600 && !fin; j++) begin
            if (bus.ESP_REQ === 1'b1) begin req_cnt++; req_last = j; end
            if (wf < 0 && bus.WAIT !== 1'b1) wf = j;
            if (bus.timeout_evt === 1'b1) begin tmo_n++; tmo_at = j; end
            if (bus.overrun_evt === 1'b1) begin ovr_n++; ovr_at = j; end
            if (bus.ESP_S !== 3'(exp_code)) s_bad++;
            if (bus.busy !== 1'b1) begin
                bf  = j;
                fin = 1'b1;
            end else begin
                bus.io_access = 1'b0;
                drive_sel(6'd0);
                if (j == fall_k) bus.ESP_DONE = 1'b0;
                if (j == rise_k) bus.ESP_DONE = 1'b1;
                if (j == ovr_k) begin
                    bus.io_access = 1'b1;
                    drive_sel(6'h01);
                end
                tick();
            end
        end
        bus.io_access = 1'b0;
        drive_sel(6'd0);
        bus.ESP_DONE = 1'b0;
        if (exp_tmo && err_model < 255) err_model++;
        chk({tag, "_finished"},   32'(fin), 1);
        chk({tag, "_esp_s"},      s_bad, 0);
        chk({tag, "_req_len"},    req_cnt, P);
        chk({tag, "_req_last"},   req_last, P - 1);
        chk({tag, "_wait_fall"},  wf, exp_wf);
        chk({tag, "_busy_fall"},  bf, exp_wf + 1);
        chk({tag, "_timeout_n"},  tmo_n, 32'(exp_tmo));
        if (exp_tmo) chk({tag, "_timeout_at"}, tmo_at, exp_wf);
        chk({tag, "_err_count"},  bus.err_count, err_model);
        chk({tag, "_overrun_n"},  ovr_n, (ovr_k >= 0) ? 1 : 0);
        if (ovr_k >= 0) chk({tag, "_overrun_at"}, ovr_at, ovr_k + 1);
        repeat (4) tick();
    endtask

    initial begin
        bus.io_access = 1'b0;
        bus.ESP_DONE  = 1'b0;
        drive_sel(6'd0);
        repeat (2) tick();
        chk("rst_esp_req",     bus.ESP_REQ, 0);
        chk("rst_wait",        bus.WAIT, 0);
        chk("rst_busy",        bus.busy, 0);
        chk("rst_esp_s",       bus.ESP_S, 0);
        chk("rst_timeout_evt", bus.timeout_evt, 0);
        chk("rst_overrun_evt", bus.overrun_evt, 0);
        chk("rst_err_count",   bus.err_count, 0);

        // a request on the first edge after release must not be taken
        RST_N = 1'b1;
        bus.io_access = 1'b1;
        drive_sel(6'b000010);
        tick();
        bus.io_access = 1'b0;
        drive_sel(6'd0);
        chk("arm_first_edge_busy", bus.busy, 0);
        repeat (3) tick();

        bus.io_access = 1'b1;
        tick();
        bus.io_access = 1'b0;
        chk("noop_busy", bus.busy, 0);
        tick();
        chk("noop_busy_late", bus.busy, 0);
        chk("noop_overrun",   bus.overrun_evt, 0);

        run_txn("frehd_out_done100",  6'b001000, 1'b0, 100,   -1, -1);
        run_txn("prio_trs_vs_prn",    6'b100001, 1'b0, 60,    -1, -1);
        run_txn("done_pulse_in_req",  6'b000100, 1'b0, 10,    13, -1);
        run_txn("done_at_req_end",    6'b010000, 1'b0, P - 3, -1, -1);
        run_txn("done_after_req",     6'b010000, 1'b0, P - 2, -1, -1);
        run_txn("overrun_req20",      6'b000010, 1'b0, 80,    -1, 20);
        run_txn("overrun_release",    6'b100000, 1'b0, 30,    -1, P);
        run_txn("done_ties_timeout",  6'b001000, 1'b0, T - 3, -1, -1);
        run_txn("done_after_timeout", 6'b001000, 1'b0, T - 2, -1, -1);
        run_txn("done_stale_high",    6'b000001, 1'b1, 75,    60, -1);
        run_txn("stale_high_timeout", 6'b000001, 1'b1, -1,    -1, -1);

        for (int n = 0; n < 20; n++) begin
            logic [5:0] s;
            int rk, ok;
            s  = 6'($urandom_range(1, 63));
            rk = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 260));
            ok = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, exp_fall(rk))) : -1;
            run_txn("rand", s, 1'b0, rk, -1, ok);
        end

        for (int n = 0; n < 300; n++) run_txn("timeout_rep", 6'b000010, 1'b0, -1, -1, -1);
        chk("err_count_saturated", bus.err_count, 255);

        // reset in the middle of WAIT_DONE must drop WAIT without a clock edge
        bus.io_access = 1'b1;
        drive_sel(6'b001000);
        tick();
        bus.io_access = 1'b0;
        drive_sel(6'd0);
        repeat (P + 30) tick();
        chk("mid_wait_before_rst", bus.WAIT, 1);
        #3;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_wait",      bus.WAIT, 0);
        chk("mid_rst_esp_req",   bus.ESP_REQ, 0);
        chk("mid_rst_busy",      bus.busy, 0);
        chk("mid_rst_err_count", bus.err_count, 0);
        err_model = 0;
        tick();
        RST_N = 1'b1;
        repeat (4) tick();
        run_txn("after_reset", 6'b001000, 1'b0, 100, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/esp_io_sched.md
ESP_IO_SCHED -- requirements
Module: esp_io_sched

Interface
REQ-001 SHALL have parameter REQ_PULSE, default 50, which sets the ESP_REQ high time in clk cycles (range 1..63).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24'd8400000 (100 ms at 84 MHz), which sets the maximum wait for ESP_DONE, counted from REQ entry.
REQ-003 SHALL have the following ports (one clock; RST_N is asynchronous, active-low):
- clk  in  1  system clock, 84 MHz
- RST_N  in  1  asynchronous active-low reset
- io_access  in  1  one-cycle pulse; the address and selects are valid this cycle
- sel_trs_io_in, sel_trs_io_out  in  1 each  port 31 IN/OUT decoded
- sel_frehd_in, sel_frehd_out  in  1 each  ports 0xC0-0xCF IN/OUT decoded
- sel_printer_rd, sel_printer_wr  in  1 each  ports 0xF8-0xFB IN/OUT decoded
- ESP_DONE  in  1  asynchronous completion level from the ESP
- ESP_REQ  out  1  request strobe to the ESP
- ESP_S  out  3  request code
- WAIT  out  1  Z80 wait request
- busy  out  1  high whenever state != IDLE
- timeout_evt  out  1  one-cycle pulse on timeout
- overrun_evt  out  1  one-cycle pulse when a request is dropped
- err_count  out  8  saturating timeout count

Function
REQ-004 SHALL encode ESP_S as: trs_io_in=0, trs_io_out=1, frehd_in=2, frehd_out=3, printer_rd=4, printer_wr=5.
REQ-005 SHALL resolve multiple asserted selects by fixed priority: trs_io_in > trs_io_out > frehd_in > frehd_out > printer_rd > printer_wr.
REQ-006 SHALL treat io_access with no select asserted as a no-op: no state change, no event.
REQ-007 SHALL implement the FSM states IDLE, REQ, WAIT_DONE and RELEASE.
REQ-008 IDLE -> REQ SHALL occur on a valid io_access; on the next edge ESP_REQ=1, WAIT=1, and ESP_S is latched.
REQ-009 In REQ, ESP_REQ SHALL stay high for exactly REQ_PULSE cycles, then go low.
REQ-010 On leaving REQ, the FSM SHALL go to RELEASE if done_seen=1, otherwise to WAIT_DONE.
REQ-011 In WAIT_DONE, the FSM SHALL go to RELEASE on a done edge, or on the timeout counter reaching TIMEOUT_CYCLES.
REQ-012 RELEASE SHALL last exactly 1 cycle with WAIT=0 and ESP_REQ=0, then return to IDLE.
REQ-013 ESP_DONE SHALL pass through a 2-FF synchronizer plus an edge register; done edge = sync2 & ~sync3.
REQ-014 A done edge SHALL be recognised only after REQ entry; an ESP_DONE already high at request time is ignored until it falls and rises again.
REQ-015 A done edge during REQ SHALL set done_seen; ESP_REQ still completes its full pulse.
REQ-016 WAIT SHALL fall exactly 3 clk edges after ESP_DONE rises (input stable before the first edge) when in WAIT_DONE.
REQ-017 The 24-bit timeout counter SHALL clear on REQ entry and increment every cycle in REQ and WAIT_DONE.
REQ-018 On timeout, timeout_evt SHALL pulse for 1 cycle together with the transition to RELEASE.
REQ-019 On timeout, err_count SHALL increment and saturate at 255.
REQ-020 If a done edge and timeout occur in the same cycle, done SHALL win: no timeout_evt and no err_count change.
REQ-021 io_access with a valid select while state != IDLE SHALL be dropped, with overrun_evt pulsing 1 cycle; the FSM and ESP_S are unaffected.
REQ-022 io_access in the RELEASE cycle SHALL be dropped and treated as an overrun; io_access in IDLE is never dropped.
REQ-023 ESP_S SHALL stay stable from REQ entry through RELEASE, and hold its last value in IDLE.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 RST_N low SHALL asynchronously force state=IDLE, with ESP_REQ=0, WAIT=0, ESP_S=0, busy=0, timeout_evt=0, overrun_evt=0, err_count=0, timeout counter=0, pulse counter=0, done_seen=0, and the synchronizer flops=0.
REQ-026 Reset asserted mid-transaction SHALL drop WAIT immediately, without waiting for a clock edge.
REQ-027 Release of RST_N SHALL be synchronized internally; the first request is accepted no earlier than the 2nd clk edge after RST_N rises.

Verification
REQ-028 io_access with sel_frehd_out; ESP_DONE rises 100 cycles later -> ESP_S=3, ESP_REQ high 50 cycles, WAIT falls 3 edges after ESP_DONE, busy low 1 cycle after WAIT falls.
REQ-029 sel_trs_io_in and sel_printer_wr both asserted -> ESP_S=0.
REQ-030 ESP_DONE pulse at cycle 10 of REQ -> ESP_REQ still lasts 50 cycles; WAIT falls at cycle 51, with no WAIT_DONE residency.
REQ-031 TIMEOUT_CYCLES=200, ESP_DONE held low -> timeout_evt at cycle 200, err_count=1, WAIT low; repeated 300 times, err_count=255.
REQ-032 Second io_access at cycle 20 of REQ -> overrun_evt pulse; ESP_S unchanged; ESP_REQ still a single 50-cycle pulse.
REQ-033 RST_N low at cycle 30 of WAIT_DONE -> WAIT=0 and ESP_REQ=0 asynchronously; after release, a new request behaves as in REQ-028.
